// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable and an auto-scan mode that steps
// through every output line, holding each one for DIV clock cycles.
module scan_decoder #(
  parameter int unsigned N           = 2,
  parameter int unsigned DIV         = 4,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      a,
  output logic [(1<<N)-1:0] d,
  output logic [N-1:0]      cur,
  output logic              wrap
);

  localparam int unsigned M  = 1 << N;
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [M-1:0]  Inactive = ACTIVE_HIGH ? {M{1'b0}} : {M{1'b1}};
  localparam logic [CW-1:0] CntLast  = CW'(DIV - 1);
  localparam logic [N-1:0]  IdxLast  = N'(M - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDirect = 2'd1,
    StScan   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [M-1:0]  d_q, d_d;
  logic [N-1:0]  cur_q, cur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;

  function automatic logic [M-1:0] decode(input logic [N-1:0] idx);
    logic [M-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return ACTIVE_HIGH ? oh : ~oh;
  endfunction

  always_comb begin
    state_d = StIdle;
    d_d     = Inactive;
    cur_d   = cur_q;
    cnt_d   = '0;
    wrap_d  = 1'b0;

    if (en) begin
      state_d = mode ? StScan : StDirect;
    end

    unique case (state_d)
      StDirect: begin
        cur_d = a;
        d_d   = decode(a);
      end
      StScan: begin
        if (state_q != StScan) begin
          // Entry edge: start at the requested index with a full dwell.
          cur_d = a;
          d_d   = decode(a);
        end else if (cnt_q == CntLast) begin
          cur_d  = cur_q + N'(1);
          d_d    = decode(cur_q + N'(1));
          wrap_d = (cur_q == IdxLast);
        end else begin
          cnt_d = cnt_q + CW'(1);
          d_d   = d_q;
        end
      end
      default: begin
        d_d = Inactive;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      d_q     <= Inactive;
      cur_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign d    = d_q;
  assign cur  = cur_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: one instance with N=2/DIV=4/active-high and one with
// N=3/DIV=1/active-low, sharing clock and reset.
module tb_scan_decoder;

  logic       clk;
  logic       rst_n;

  logic       en_a, mode_a;
  logic [1:0] sel_a;
  logic [3:0] d_a;
  logic [1:0] cur_a;
  logic       wrap_a;

  logic       en_b, mode_b;
  logic [2:0] sel_b;
  logic [7:0] d_b;
  logic [2:0] cur_b;
  logic       wrap_b;

  int checks   = 0;
  int failures = 0;

  scan_decoder #(.N(2), .DIV(4), .ACTIVE_HIGH(1'b1)) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en_a),
    .mode (mode_a),
    .a    (sel_a),
    .d    (d_a),
    .cur  (cur_a),
    .wrap (wrap_a)
  );

  scan_decoder #(.N(3), .DIV(1), .ACTIVE_HIGH(1'b0)) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en_b),
    .mode (mode_b),
    .a    (sel_b),
    .d    (d_b),
    .cur  (cur_b),
    .wrap (wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    rst_n  = 1'b1;
    en_a   = 1'b1;
    mode_a = 1'b0;
    sel_a  = 2'd1;
    en_b   = 1'b0;
    mode_b = 1'b0;
    sel_b  = 3'd0;
    tick();
    tick();

    // Asynchronous reset in the middle of a cycle.
    #3 rst_n = 1'b0;
    #1;
    check("rst_d_a", d_a, 64'h0);
    check("rst_cur_a", cur_a, 64'h0);
    check("rst_wrap_a", wrap_a, 64'h0);
    check("rst_d_b", d_b, 64'hFF);
    en_a = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_d_a", d_a, 64'h0);
    end

    // Direct decode sweep.
    for (int i = 0; i < 4; i++) begin
      en_a   = 1'b1;
      mode_a = 1'b0;
      sel_a  = 2'(i);
      tick();
      check("direct_d", d_a, 64'(1) << i);
      check("direct_cur", cur_a, 64'(i));
    end
    en_a = 1'b0;
    tick();
    check("dis_d", d_a, 64'h0);
    check("dis_cur", cur_a, 64'h3);

    // Scan from index 2, DIV=4; a changes after entry and must be ignored.
    en_a   = 1'b1;
    mode_a = 1'b1;
    sel_a  = 2'd2;
    for (int k = 0; k < 16; k++) begin
      tick();
      sel_a = 2'($urandom_range(0, 3));
      idx   = (2 + k / 4) % 4;
      check("scan_d", d_a, 64'(1) << idx);
      check("scan_cur", cur_a, 64'(idx));
      check("scan_wrap", wrap_a, (k == 8) ? 64'h1 : 64'h0);
    end

    // Two cycles at index 1, then switch to direct with a=3.
    mode_a = 1'b0;
    sel_a  = 2'd1;
    tick();
    mode_a = 1'b1;
    tick();
    tick();
    check("mid_idx1", d_a, 64'h2);
    mode_a = 1'b0;
    sel_a  = 2'd3;
    tick();
    check("mid_direct", d_a, 64'h8);

    // Re-enter scan at the current a with a full dwell.
    mode_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("reent_d", d_a, (k < 4) ? 64'h8 : 64'h1);
      check("reent_wrap", wrap_a, (k == 4) ? 64'h1 : 64'h0);
    end
    tick();
    en_a = 1'b0;
    tick();
    check("mid_en_d", d_a, 64'h0);
    check("mid_en_cur", cur_a, 64'h0);
    en_a  = 1'b1;
    sel_a = 2'd2;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("restart_d", d_a, (k < 4) ? 64'h4 : 64'h8);
    end
    en_a = 1'b0;

    // DIV=1, active-low, N=3: advance every cycle, wrap every 8.
    en_b   = 1'b1;
    mode_b = 1'b1;
    sel_b  = 3'd0;
    for (int k = 0; k < 17; k++) begin
      tick();
      sel_b = 3'($urandom_range(0, 7));
      check("fast_d", d_b, 64'hFF & ~(64'(1) << (k % 8)));
      check("fast_cur", cur_b, 64'(k % 8));
      check("fast_wrap", wrap_b, (k > 0 && k % 8 == 0) ? 64'h1 : 64'h0);
    end

    #3 rst_n = 1'b0;
    #1;
    check("rst2_d_b", d_b, 64'hFF);
    check("rst2_cur_b", cur_b, 64'h0);
    check("rst2_wrap_b", wrap_b, 64'h0);
    check("rst2_d_a", d_a, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
